csr_trap_unit: RTL and testbench

- Machine-mode CSR file. Acts as the responder on the CSR write port driven by the exception handler.
- Implements the trap-related CSRs (`mstatus`, `mtvec`, `mepc`, `mcause`, `mtval`, `mscratch`) and the 64-bit `mcycle`/`minstret` counters.
- Serves CSR instructions from the execute stage.
- Performs trap entry and `mret` state updates. Exports the trap vector and return PC to the fetch redirect logic.

---
 rtl/rv32_pkg.sv | 49 ++++
 rtl/csr_counter64.sv | 29 ++
 rtl/csr_trap_unit.sv | 180 ++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 machine-mode definitions: CSR opcodes, CSR addresses, cause codes
// and the read-modify-write helper used by the CSR file.
package rv32_pkg;

  typedef enum logic [1:0] {
    CSR_RW = 2'd1,
    CSR_RS = 2'd2,
    CSR_RC = 2'd3
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [4:0] EXC_INSTR_MISALIGNED = 5'd0;
  localparam logic [4:0] EXC_ILLEGAL_INSTR    = 5'd2;
  localparam logic [4:0] EXC_LOAD_MISALIGNED  = 5'd4;
  localparam logic [4:0] EXC_STORE_MISALIGNED = 5'd6;

  localparam logic [31:0] EXCEPTION_HANDLER_ADDR = 32'h0000_0100;
  localparam logic [31:0] MISA_VALUE             = 32'h4000_0100;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  function automatic logic [31:0] csr_apply(input csr_op_e op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    logic [31:0] res;
    res = old_val;
    case (op)
      CSR_RW:  res = wdata;
      CSR_RS:  res = old_val | wdata;
      CSR_RC:  res = old_val & ~wdata;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes; a write to
// either half takes precedence over the increment in that cycle.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  logic [63:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (wr_lo_i) value_d[31:0] = wdata_i;
    if (wr_hi_i) value_d[63:32] = wdata_i;
    if (!wr_lo_i && !wr_hi_i && inc_i) value_d = value_q + 64'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) value_q <= '0;
    else         value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file: trap CSRs, mcycle/minstret counters, trap entry and
// mret sequencing, and the trap vector / return PC used by fetch redirect.
module csr_trap_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = EXCEPTION_HANDLER_ADDR,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        csr_valid_i,
  input  csr_op_e     csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        exc_csr_we_i,
  input  logic [11:0] exc_csr_addr_i,
  input  logic [31:0] exc_csr_wdata_i,
  output logic [31:0] exc_csr_rdata_o,
  input  logic        trap_i,
  input  logic [4:0]  trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic        mret_i,
  input  logic        retire_i,
  output logic [31:0] trap_vector_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [29:0] mtvec_q, mtvec_d;
  logic [29:0] mepc_q, mepc_d;
  logic        mcause_int_q, mcause_int_d;
  logic [4:0]  mcause_code_q, mcause_code_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] mscratch_q, mscratch_d;

  logic [63:0] mcycle, minstret;
  logic [31:0] mstatus_val, mcause_val;

  logic        instr_hit, exc_hit;
  logic [31:0] instr_old, exc_val;
  logic        wr_attempt, instr_we;
  logic [31:0] instr_new;
  logic        exc_mtval_we;

  logic        unused_trap_pc;
  assign unused_trap_pc = ^trap_pc_i[1:0];

  // MPP is hardwired to machine mode.
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign mcause_val  = {mcause_int_q, 26'b0, mcause_code_q};

  function automatic logic [32:0] read_csr(input logic [11:0] addr);
    logic [32:0] r;
    r = '0;
    case (addr)
      CSR_MSTATUS:   r = {1'b1, mstatus_val};
      CSR_MISA:      r = {1'b1, MISA_VALUE};
      CSR_MTVEC:     r = {1'b1, mtvec_q, 2'b00};
      CSR_MSCRATCH:  r = {1'b1, mscratch_q};
      CSR_MEPC:      r = {1'b1, mepc_q, 2'b00};
      CSR_MCAUSE:    r = {1'b1, mcause_val};
      CSR_MTVAL:     r = {1'b1, mtval_q};
      CSR_MCYCLE:    r = {1'b1, mcycle[31:0]};
      CSR_MCYCLEH:   r = {1'b1, mcycle[63:32]};
      CSR_MINSTRET:  r = {1'b1, minstret[31:0]};
      CSR_MINSTRETH: r = {1'b1, minstret[63:32]};
      CSR_MHARTID:   r = {1'b1, HART_ID};
      default:       r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    {instr_hit, instr_old} = read_csr(csr_addr_i);
    {exc_hit, exc_val}     = read_csr(exc_csr_addr_i);
  end

  // RS/RC with zero write data are pure reads and never count as writes.
  assign wr_attempt    = csr_valid_i && (csr_op_i == CSR_RW || csr_wdata_i != 32'd0);
  assign csr_illegal_o = csr_valid_i &&
                         (!instr_hit || (wr_attempt && csr_addr_i[11:10] == 2'b11));
  assign csr_rdata_o   = csr_illegal_o ? 32'd0 : instr_old;
  assign exc_csr_rdata_o = exc_hit ? exc_val : 32'd0;

  assign instr_we     = wr_attempt && !csr_illegal_o && !trap_i;
  assign instr_new    = csr_apply(csr_op_i, instr_old, csr_wdata_i);
  assign exc_mtval_we = exc_csr_we_i && exc_csr_addr_i == CSR_MTVAL;

  always_comb begin
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_int_d  = mcause_int_q;
    mcause_code_d = mcause_code_q;
    mtval_d       = mtval_q;
    mscratch_d    = mscratch_q;

    if (trap_i) begin
      mpie_d = mie_q;
      mie_d  = 1'b0;
    end else if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (instr_we && csr_addr_i == CSR_MSTATUS) begin
      mie_d  = instr_new[MSTATUS_MIE_BIT];
      mpie_d = instr_new[MSTATUS_MPIE_BIT];
    end

    if (trap_i) begin
      mepc_d        = trap_pc_i[31:2];
      mcause_int_d  = 1'b0;
      mcause_code_d = trap_cause_i;
    end else if (instr_we) begin
      if (csr_addr_i == CSR_MEPC) mepc_d = instr_new[31:2];
      if (csr_addr_i == CSR_MCAUSE) begin
        mcause_int_d  = instr_new[31];
        mcause_code_d = instr_new[4:0];
      end
    end

    if (instr_we && csr_addr_i == CSR_MTVEC)    mtvec_d    = instr_new[31:2];
    if (instr_we && csr_addr_i == CSR_MSCRATCH) mscratch_d = instr_new;

    // The exception handler's mtval write outranks any instruction write.
    if (exc_mtval_we)                         mtval_d = exc_csr_wdata_i;
    else if (instr_we && csr_addr_i == CSR_MTVAL) mtval_d = instr_new;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= MTVEC_RESET[31:2];
      mepc_q        <= '0;
      mcause_int_q  <= 1'b0;
      mcause_code_q <= '0;
      mtval_q       <= '0;
      mscratch_q    <= '0;
    end else begin
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_int_q  <= mcause_int_d;
      mcause_code_q <= mcause_code_d;
      mtval_q       <= mtval_d;
      mscratch_q    <= mscratch_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (1'b1),
    .wr_lo_i (instr_we && csr_addr_i == CSR_MCYCLE),
    .wr_hi_i (instr_we && csr_addr_i == CSR_MCYCLEH),
    .wdata_i (instr_new),
    .value_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (retire_i && !trap_i),
    .wr_lo_i (instr_we && csr_addr_i == CSR_MINSTRET),
    .wr_hi_i (instr_we && csr_addr_i == CSR_MINSTRETH),
    .wdata_i (instr_new),
    .value_o (minstret)
  );

  assign trap_vector_o = {mtvec_q, 2'b00};
  assign mepc_o        = {mepc_q, 2'b00};
  assign mie_o         = mie_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: expected values are queued as stimulus is
// driven and popped when the DUT outputs are sampled.
module tb_csr_trap_unit;
  import rv32_pkg::*;

  localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_0207;
  localparam logic [31:0] TB_HART_ID     = 32'h0000_0005;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_valid;
  csr_op_e     csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        exc_we;
  logic [11:0] exc_addr;
  logic [31:0] exc_wdata;
  logic [31:0] exc_rdata;
  logic        trap;
  logic [4:0]  trap_cause;
  logic [31:0] trap_pc;
  logic        mret;
  logic        retire;
  logic [31:0] trap_vector;
  logic [31:0] mepc;
  logic        mie;

  always #5 clk = ~clk;

  csr_trap_unit #(
    .MTVEC_RESET (TB_MTVEC_RESET),
    .HART_ID     (TB_HART_ID)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .csr_valid_i     (csr_valid),
    .csr_op_i        (csr_op),
    .csr_addr_i      (csr_addr),
    .csr_wdata_i     (csr_wdata),
    .csr_rdata_o     (csr_rdata),
    .csr_illegal_o   (csr_illegal),
    .exc_csr_we_i    (exc_we),
    .exc_csr_addr_i  (exc_addr),
    .exc_csr_wdata_i (exc_wdata),
    .exc_csr_rdata_o (exc_rdata),
    .trap_i          (trap),
    .trap_cause_i    (trap_cause),
    .trap_pc_i       (trap_pc),
    .mret_i          (mret),
    .retire_i        (retire),
    .trap_vector_o   (trap_vector),
    .mepc_o          (mepc),
    .mie_o           (mie)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    n_total++;
    assert (obs === e.val) n_pass++;
    else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push(tag, exp);
    check(obs);
  endtask

  // Pure read (RS with zero data) sampled 1ns after the falling edge.
  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag,
                    input logic exp_ill = 1'b0);
    @(negedge clk);
    csr_valid = 1'b1;
    csr_op    = CSR_RS;
    csr_addr  = addr;
    csr_wdata = 32'd0;
    push(tag, exp);
    push({tag, "_ill"}, {31'b0, exp_ill});
    #1;
    check(csr_rdata);
    check({31'b0, csr_illegal});
    csr_valid = 1'b0;
  endtask

  task automatic wr(input csr_op_e op, input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    csr_valid = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = data;
    @(posedge clk);
    #1;
    csr_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    csr_valid  = 1'b0;
    csr_op     = CSR_RS;
    csr_addr   = 12'h000;
    csr_wdata  = 32'd0;
    exc_we     = 1'b0;
    exc_addr   = 12'h000;
    exc_wdata  = 32'd0;
    trap       = 1'b0;
    trap_cause = 5'd0;
    trap_pc    = 32'd0;
    mret       = 1'b0;
    retire     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    rd(CSR_MCYCLE, 32'd1, "mcycle_after_reset");
    rd(CSR_MSTATUS, 32'h0000_1800, "mstatus_reset");
    rd(CSR_MTVEC, TB_MTVEC_RESET & ~32'd3, "mtvec_reset");
    chk("trap_vector_reset", trap_vector, 32'h0000_0204);
    chk("mie_reset", {31'b0, mie}, 32'd0);
    chk("mepc_o_reset", mepc, 32'd0);
    rd(CSR_MISA, 32'h4000_0100, "misa");

    // mtvec instruction writes
    wr(CSR_RW, CSR_MTVEC, 32'h0000_2003);
    rd(CSR_MTVEC, 32'h0000_2000, "mtvec_rw");
    wr(CSR_RS, CSR_MTVEC, 32'h0000_0010);
    rd(CSR_MTVEC, 32'h0000_2010, "mtvec_rs");
    chk("trap_vector_rs", trap_vector, 32'h0000_2010);
    wr(CSR_RC, CSR_MTVEC, 32'h0000_2000);
    rd(CSR_MTVEC, 32'h0000_0010, "mtvec_rc");

    // Trap entry with exception-port mtval write
    wr(CSR_RS, CSR_MSTATUS, 32'h0000_0008);
    rd(CSR_MSTATUS, 32'h0000_1808, "mstatus_mie_set");
    chk("mie_o_set", {31'b0, mie}, 32'd1);
    @(negedge clk);
    trap       = 1'b1;
    trap_cause = EXC_ILLEGAL_INSTR;
    trap_pc    = 32'h0000_0084;
    exc_we     = 1'b1;
    exc_addr   = CSR_MTVAL;
    exc_wdata  = 32'h0000_0084;
    #1;
    chk("trap_vector_same_cycle", trap_vector, 32'h0000_0010);
    chk("mepc_o_before_edge", mepc, 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    chk("mepc_o_after_trap", mepc, 32'h0000_0084);
    chk("mie_o_after_trap", {31'b0, mie}, 32'd0);
    rd(CSR_MEPC, 32'h0000_0084, "mepc_trap");
    rd(CSR_MCAUSE, 32'd2, "mcause_trap");
    rd(CSR_MTVAL, 32'h0000_0084, "mtval_trap");
    rd(CSR_MSTATUS, 32'h0000_1880, "mstatus_trap");

    @(negedge clk);
    mret = 1'b1;
    @(posedge clk);
    #1;
    mret = 1'b0;
    rd(CSR_MSTATUS, 32'h0000_1888, "mstatus_mret");

    // One retire, then a trap that suppresses write, retire and mret
    @(negedge clk);
    retire = 1'b1;
    @(posedge clk);
    #1;
    retire = 1'b0;
    rd(CSR_MINSTRET, 32'd1, "minstret_one");
    @(negedge clk);
    trap       = 1'b1;
    trap_cause = EXC_STORE_MISALIGNED;
    trap_pc    = 32'h0000_0103;
    retire     = 1'b1;
    mret       = 1'b1;
    csr_valid  = 1'b1;
    csr_op     = CSR_RW;
    csr_addr   = CSR_MSCRATCH;
    csr_wdata  = 32'h0000_DEAD;
    @(posedge clk);
    #1;
    idle_inputs();
    rd(CSR_MSCRATCH, 32'd0, "mscratch_trap_suppressed");
    rd(CSR_MINSTRET, 32'd1, "minstret_trap_suppressed");
    rd(CSR_MEPC, 32'h0000_0100, "mepc_aligned");
    rd(CSR_MCAUSE, 32'd6, "mcause_store");
    rd(CSR_MSTATUS, 32'h0000_1880, "mstatus_mret_suppressed");

    // mret beats an instruction write to mstatus
    @(negedge clk);
    mret      = 1'b1;
    csr_valid = 1'b1;
    csr_op    = CSR_RW;
    csr_addr  = CSR_MSTATUS;
    csr_wdata = 32'd0;
    @(posedge clk);
    #1;
    idle_inputs();
    rd(CSR_MSTATUS, 32'h0000_1888, "mstatus_mret_wins");

    // Exception port beats instruction write to mtval; other addresses ignored
    @(negedge clk);
    csr_valid = 1'b1;
    csr_op    = CSR_RW;
    csr_addr  = CSR_MTVAL;
    csr_wdata = 32'h0000_0111;
    exc_we    = 1'b1;
    exc_addr  = CSR_MTVAL;
    exc_wdata = 32'h0000_0222;
    @(posedge clk);
    #1;
    idle_inputs();
    rd(CSR_MTVAL, 32'h0000_0222, "mtval_exc_wins");
    @(negedge clk);
    exc_we    = 1'b1;
    exc_addr  = CSR_MSCRATCH;
    exc_wdata = 32'h0000_0055;
    #1;
    chk("exc_rdata_mscratch", exc_rdata, 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    rd(CSR_MSCRATCH, 32'd0, "mscratch_exc_ignored");
    exc_addr = CSR_MEPC;
    #1;
    chk("exc_rdata_mepc", exc_rdata, 32'h0000_0100);

    // Illegal accesses
    @(negedge clk);
    csr_valid = 1'b1;
    csr_op    = CSR_RW;
    csr_addr  = CSR_MHARTID;
    csr_wdata = 32'd1;
    #1;
    chk("mhartid_rw_illegal", {31'b0, csr_illegal}, 32'd1);
    chk("mhartid_rw_rdata", csr_rdata, 32'd0);
    csr_valid = 1'b0;
    rd(CSR_MHARTID, TB_HART_ID, "mhartid_read");
    rd(12'h7C0, 32'd0, "addr_7c0", 1'b1);

    // mcycle write and carry into the upper half
    wr(CSR_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
    rd(CSR_MCYCLE, 32'hFFFF_FFFF, "mcycle_written");
    rd(CSR_MCYCLE, 32'd0, "mcycle_wrapped_lo");
    rd(CSR_MCYCLEH, 32'd1, "mcycleh_carry");

    // minstret upper-half write and full 64-bit wrap
    wr(CSR_RW, CSR_MINSTRETH, 32'h0000_000A);
    rd(CSR_MINSTRETH, 32'h0000_000A, "minstreth_written");
    rd(CSR_MINSTRET, 32'd1, "minstret_lo_kept");
    wr(CSR_RW, CSR_MINSTRET, 32'hFFFF_FFFF);
    wr(CSR_RW, CSR_MINSTRETH, 32'hFFFF_FFFF);
    @(negedge clk);
    retire = 1'b1;
    @(posedge clk);
    #1;
    retire = 1'b0;
    rd(CSR_MINSTRET, 32'd0, "minstret_wrap_lo");
    rd(CSR_MINSTRETH, 32'd0, "minstret_wrap_hi");

    // Asynchronous reset mid-operation
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("trap_vector_async_reset", trap_vector, 32'h0000_0204);
    chk("mie_async_reset", {31'b0, mie}, 32'd0);
    chk("mepc_o_async_reset", mepc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(CSR_MCYCLE, 32'd1, "mcycle_after_rereset");
    rd(CSR_MTVAL, 32'd0, "mtval_after_rereset");
    rd(CSR_MSTATUS, 32'h0000_1800, "mstatus_after_rereset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
